sd_wb_master_arbiter: RTL and testbench

- Shares the single SD-controller Wishbone master port between two DMA requesters.
  - Requester 0: the TX FIFO filler, which reads memory.
  - Requester 1: the RX FIFO drainer, which writes memory.
- Arbitration is round-robin with grant locked for a whole cycle (cyc) and a watchdog timeout per cycle.
- Sits between the two filler/drainer masters and the system bus interconnect.

---
 rtl/sd_wb_arb_pkg.sv | 17 +
 rtl/sd_wb_arb_watchdog.sv | 47 ++++
 rtl/sd_wb_master_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sd_wb_master_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_wb_arb_pkg.sv
// Shared types and constants for the SD-controller Wishbone master arbiter.
// State encoding, requester indices and the watchdog counter width live here.
package sd_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    localparam logic OWNER_TX = 1'b0;
    localparam logic OWNER_RX = 1'b1;

    localparam int WD_W = 16;

endpackage

// File: rtl/sd_wb_arb_watchdog.sv
// Stall watchdog: counts strobed cycles without ack/err while a requester owns
// the bus and flags the cycle on which the stall limit is reached.
module sd_wb_arb_watchdog
    import sd_wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic stb,
    input  logic ack,
    input  logic err,
    output logic expire
);

    localparam int unsigned LIM_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WD_W-1:0] LIMIT = WD_W'(LIM_INT);

    logic [WD_W-1:0] cnt_q, cnt_d;
    logic            stall;

    assign stall = en && stb && !ack && !err;

    // Saturating count; a disabled watchdog keeps the counter pinned at zero.
    always_comb begin
        cnt_d = '0;
        if ((TIMEOUT != 0) && stall) begin
            if (cnt_q != {WD_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (TIMEOUT != 0) && stall && (cnt_q == LIMIT);

endmodule

// File: rtl/sd_wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between the TX filler
// (requester 0) and the RX drainer (requester 1), with per-cycle watchdog abort.
module sd_wb_master_arbiter
    import sd_wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADR_W-1:0] s0_wb_adr_i,
    input  logic [DAT_W-1:0] s0_wb_dat_i,
    input  logic             s0_wb_we_i,
    input  logic             s0_wb_cyc_i,
    input  logic             s0_wb_stb_i,
    input  logic [2:0]       s0_wb_cti_i,
    input  logic [1:0]       s0_wb_bte_i,
    output logic [DAT_W-1:0] s0_wb_dat_o,
    output logic             s0_wb_ack_o,
    output logic             s0_wb_err_o,
    input  logic [ADR_W-1:0] s1_wb_adr_i,
    input  logic [DAT_W-1:0] s1_wb_dat_i,
    input  logic             s1_wb_we_i,
    input  logic             s1_wb_cyc_i,
    input  logic             s1_wb_stb_i,
    input  logic [2:0]       s1_wb_cti_i,
    input  logic [1:0]       s1_wb_bte_i,
    output logic [DAT_W-1:0] s1_wb_dat_o,
    output logic             s1_wb_ack_o,
    output logic             s1_wb_err_o,
    output logic [ADR_W-1:0] m_wb_adr_o,
    output logic [DAT_W-1:0] m_wb_dat_o,
    output logic             m_wb_we_o,
    output logic             m_wb_cyc_o,
    output logic             m_wb_stb_o,
    output logic [2:0]       m_wb_cti_o,
    output logic [1:0]       m_wb_bte_o,
    input  logic [DAT_W-1:0] m_wb_dat_i,
    input  logic             m_wb_ack_i,
    input  logic             m_wb_err_i,
    output logic [1:0]       gnt_o,
    output logic             timeout_o
);

    logic [ADR_W-1:0] s_adr [2];
    logic [DAT_W-1:0] s_dat [2];
    logic             s_we  [2];
    logic             s_cyc [2];
    logic             s_stb [2];
    logic [2:0]       s_cti [2];
    logic [1:0]       s_bte [2];
    logic [DAT_W-1:0] r_dat [2];
    logic             r_ack [2];
    logic             r_err [2];

    assign s_adr[0] = s0_wb_adr_i;  assign s_adr[1] = s1_wb_adr_i;
    assign s_dat[0] = s0_wb_dat_i;  assign s_dat[1] = s1_wb_dat_i;
    assign s_we[0]  = s0_wb_we_i;   assign s_we[1]  = s1_wb_we_i;
    assign s_cyc[0] = s0_wb_cyc_i;  assign s_cyc[1] = s1_wb_cyc_i;
    assign s_stb[0] = s0_wb_stb_i;  assign s_stb[1] = s1_wb_stb_i;
    assign s_cti[0] = s0_wb_cti_i;  assign s_cti[1] = s1_wb_cti_i;
    assign s_bte[0] = s0_wb_bte_i;  assign s_bte[1] = s1_wb_bte_i;

    assign s0_wb_dat_o = r_dat[0];  assign s1_wb_dat_o = r_dat[1];
    assign s0_wb_ack_o = r_ack[0];  assign s1_wb_ack_o = r_ack[1];
    assign s0_wb_err_o = r_err[0];  assign s1_wb_err_o = r_err[1];

    arb_state_e state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       drain_k_q, drain_k_d;
    logic       tmo_q, tmo_d;
    logic       own_active;
    logic       sel;
    logic       expire;

    assign own_active = (state_q == OWN0) || (state_q == OWN1);
    assign sel        = (state_q == OWN1) || ((state_q == DRAIN) && drain_k_q);
    assign timeout_o  = tmo_q;

    sd_wb_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .en     (own_active),
        .stb    (m_wb_stb_o),
        .ack    (m_wb_ack_i),
        .err    (m_wb_err_i),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_RX;
            drain_k_q    <= OWNER_TX;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            drain_k_q    <= drain_k_d;
            tmo_q        <= tmo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        drain_k_d    = drain_k_q;
        tmo_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_cyc[0] && s_cyc[1]) begin
                    state_d = last_owner_q ? OWN0 : OWN1;
                end else if (s_cyc[0]) begin
                    state_d = OWN0;
                end else if (s_cyc[1]) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                // Expiry wins over a simultaneous cyc drop so the abort is always reported.
                if (expire) begin
                    state_d   = DRAIN;
                    drain_k_d = sel;
                    tmo_d     = 1'b1;
                end else if (!s_cyc[sel]) begin
                    state_d      = IDLE;
                    last_owner_d = sel;
                end
            end
            DRAIN: begin
                if (!s_cyc[drain_k_q]) begin
                    state_d      = IDLE;
                    last_owner_d = drain_k_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_wb_adr_o = '0;
        m_wb_dat_o = '0;
        m_wb_we_o  = 1'b0;
        m_wb_cyc_o = 1'b0;
        m_wb_stb_o = 1'b0;
        m_wb_cti_o = '0;
        m_wb_bte_o = '0;
        gnt_o      = '0;
        r_dat[0]   = '0;
        r_dat[1]   = '0;
        r_ack[0]   = 1'b0;
        r_ack[1]   = 1'b0;
        r_err[0]   = 1'b0;
        r_err[1]   = 1'b0;
        if (own_active) begin
            m_wb_adr_o = s_adr[sel];
            m_wb_dat_o = s_dat[sel];
            m_wb_we_o  = s_we[sel];
            m_wb_cyc_o = s_cyc[sel];
            m_wb_stb_o = s_stb[sel];
            m_wb_cti_o = s_cti[sel];
            m_wb_bte_o = s_bte[sel];
            gnt_o[sel] = 1'b1;
            r_dat[sel] = m_wb_dat_i;
            r_ack[sel] = m_wb_ack_i;
            r_err[sel] = m_wb_err_i;
        end else if (state_q == DRAIN) begin
            gnt_o[drain_k_q] = 1'b1;
            r_err[drain_k_q] = tmo_q;
        end
    end

endmodule

// File: tb/tb_sd_wb_master_arbiter.sv
// Self-checking bench for sd_wb_master_arbiter: directed scenarios plus random
// request rounds checked against a transaction-level arbitration model.
module tb_sd_wb_master_arbiter;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] s_adr [2];
    logic [31:0] s_dat [2];
    logic        s_we  [2];
    logic        s_cyc [2];
    logic        s_stb [2];
    logic [2:0]  s_cti [2];
    logic [1:0]  s_bte [2];
    logic [31:0] so_dat [2];
    logic        so_ack [2];
    logic        so_err [2];
    logic [31:0] m_adr, m_dat, m_dat_i;
    logic        m_we, m_cyc, m_stb, m_ack, m_err;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic [1:0]  gnt;
    logic        tmo;

    // Per-requester transaction description consumed by serve().
    int          t_delay [2];
    int          t_kind  [2];
    logic [31:0] t_rdat  [2];

    int checks = 0;
    int errors = 0;
    int last_owner;

    sd_wb_master_arbiter #(.TIMEOUT(TMO), .ADR_W(32), .DAT_W(32)) dut (
        .clk(clk), .rst(rst),
        .s0_wb_adr_i(s_adr[0]), .s0_wb_dat_i(s_dat[0]), .s0_wb_we_i(s_we[0]),
        .s0_wb_cyc_i(s_cyc[0]), .s0_wb_stb_i(s_stb[0]), .s0_wb_cti_i(s_cti[0]),
        .s0_wb_bte_i(s_bte[0]), .s0_wb_dat_o(so_dat[0]), .s0_wb_ack_o(so_ack[0]),
        .s0_wb_err_o(so_err[0]),
        .s1_wb_adr_i(s_adr[1]), .s1_wb_dat_i(s_dat[1]), .s1_wb_we_i(s_we[1]),
        .s1_wb_cyc_i(s_cyc[1]), .s1_wb_stb_i(s_stb[1]), .s1_wb_cti_i(s_cti[1]),
        .s1_wb_bte_i(s_bte[1]), .s1_wb_dat_o(so_dat[1]), .s1_wb_ack_o(so_ack[1]),
        .s1_wb_err_o(so_err[1]),
        .m_wb_adr_o(m_adr), .m_wb_dat_o(m_dat), .m_wb_we_o(m_we), .m_wb_cyc_o(m_cyc),
        .m_wb_stb_o(m_stb), .m_wb_cti_o(m_cti), .m_wb_bte_o(m_bte),
        .m_wb_dat_i(m_dat_i), .m_wb_ack_i(m_ack), .m_wb_err_i(m_err),
        .gnt_o(gnt), .timeout_o(tmo)
    );

    // Second instance with the watchdog disabled, driven only by requester 0.
    logic        z_cyc = 1'b0, z_stb = 1'b0, z_lo = 1'b0;
    logic [31:0] z_w32 = 32'h0;
    logic [2:0]  z_w3 = 3'h0;
    logic [1:0]  z_w2 = 2'h0;
    logic [31:0] z_dat0, z_dat1, z_madr, z_mdat;
    logic        z_ack0, z_err0, z_ack1, z_err1, z_mwe, z_mcyc, z_mstb, z_tmo;
    logic [2:0]  z_mcti;
    logic [1:0]  z_mbte, z_gnt;

    sd_wb_master_arbiter #(.TIMEOUT(0), .ADR_W(32), .DAT_W(32)) dut0 (
        .clk(clk), .rst(rst),
        .s0_wb_adr_i(z_w32), .s0_wb_dat_i(z_w32), .s0_wb_we_i(z_lo),
        .s0_wb_cyc_i(z_cyc), .s0_wb_stb_i(z_stb), .s0_wb_cti_i(z_w3),
        .s0_wb_bte_i(z_w2), .s0_wb_dat_o(z_dat0), .s0_wb_ack_o(z_ack0),
        .s0_wb_err_o(z_err0),
        .s1_wb_adr_i(z_w32), .s1_wb_dat_i(z_w32), .s1_wb_we_i(z_lo),
        .s1_wb_cyc_i(z_lo), .s1_wb_stb_i(z_lo), .s1_wb_cti_i(z_w3),
        .s1_wb_bte_i(z_w2), .s1_wb_dat_o(z_dat1), .s1_wb_ack_o(z_ack1),
        .s1_wb_err_o(z_err1),
        .m_wb_adr_o(z_madr), .m_wb_dat_o(z_mdat), .m_wb_we_o(z_mwe), .m_wb_cyc_o(z_mcyc),
        .m_wb_stb_o(z_mstb), .m_wb_cti_o(z_mcti), .m_wb_bte_o(z_mbte),
        .m_wb_dat_i(z_w32), .m_wb_ack_i(z_lo), .m_wb_err_i(z_lo),
        .gnt_o(z_gnt), .timeout_o(z_tmo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input int k, input logic [31:0] adr, input logic [31:0] dat,
                         input logic we, input int delay, input int kind, input logic [31:0] rdat);
        s_adr[k] = adr;
        s_dat[k] = dat;
        s_we[k]  = we;
        s_cti[k] = 3'($urandom_range(0, 7));
        s_bte[k] = 2'($urandom_range(0, 3));
        t_delay[k] = delay;
        t_kind[k]  = kind;
        t_rdat[k]  = rdat;
    endtask

    function automatic logic [1:0] onehot(input int k);
        return (k == 1) ? 2'b10 : 2'b01;
    endfunction

    // Called in the first cycle requester k should own the bus; returns in the IDLE cycle after.
    task automatic serve(input int k);
        int o;
        o = 1 - k;
        chk("own_gnt", gnt, onehot(k));
        chk("own_cyc", m_cyc, 1);
        chk("own_stb", m_stb, 1);
        chk("own_adr", m_adr, s_adr[k]);
        chk("own_wdat", m_dat, s_dat[k]);
        chk("own_we", m_we, s_we[k]);
        chk("own_cti", m_cti, s_cti[k]);
        chk("own_bte", m_bte, s_bte[k]);
        for (int d = 0; d < TMO && d <= t_delay[k]; d++) begin
            if (d == t_delay[k]) begin
                m_ack = (t_kind[k] == 0);
                m_err = (t_kind[k] != 0);
                m_dat_i = t_rdat[k];
                #1;
                chk("rsp_ack", so_ack[k], t_kind[k] == 0);
                chk("rsp_err", so_err[k], t_kind[k] != 0);
                chk("rsp_dat", so_dat[k], t_rdat[k]);
                chk("rsp_other_ack", so_ack[o], 0);
                chk("rsp_other_err", so_err[o], 0);
                chk("rsp_other_dat", so_dat[o], 0);
                chk("rsp_no_tmo", tmo, 0);
                step();
                m_ack = 1'b0;
                m_err = 1'b0;
                m_dat_i = $urandom();
            end else begin
                chk("stall_tmo", tmo, 0);
                chk("stall_err", so_err[k], 0);
                step();
            end
        end
        if (t_delay[k] >= TMO) begin
            chk("wd_tmo", tmo, 1);
            chk("wd_err", so_err[k], 1);
            chk("wd_err_other", so_err[o], 0);
            chk("wd_cyc", m_cyc, 0);
            chk("wd_stb", m_stb, 0);
            chk("wd_gnt", gnt, onehot(k));
            step();
            chk("wd_tmo_once", tmo, 0);
            chk("wd_err_once", so_err[k], 0);
            chk("drain_gnt", gnt, onehot(k));
            chk("drain_cyc", m_cyc, 0);
        end
        s_cyc[k] = 1'b0;
        s_stb[k] = 1'b0;
        #1;
        chk("drop_cyc", m_cyc, 0);
        step();
        chk("idle_gnt", gnt, 0);
        chk("idle_cyc", m_cyc, 0);
    endtask

    // Reference arbitration: single requester wins; contention goes to the one not served last.
    task automatic round(input int mask);
        int first;
        for (int k = 0; k < 2; k++) begin
            if (mask[k]) begin
                s_cyc[k] = 1'b1;
                s_stb[k] = 1'b1;
            end
        end
        #1;
        chk("pre_grant_gnt", gnt, 0);
        step();
        first = (mask == 3) ? (1 - last_owner) : ((mask == 2) ? 1 : 0);
        serve(first);
        last_owner = first;
        if (mask == 3) begin
            step();
            serve(1 - first);
            last_owner = 1 - first;
        end
    endtask

    initial begin
        int zt;
        for (int k = 0; k < 2; k++) begin
            s_adr[k] = '0; s_dat[k] = '0; s_we[k] = 1'b0; s_cyc[k] = 1'b0;
            s_stb[k] = 1'b0; s_cti[k] = '0; s_bte[k] = '0;
            t_delay[k] = 0; t_kind[k] = 0; t_rdat[k] = '0;
        end
        m_dat_i = '0; m_ack = 1'b0; m_err = 1'b0;
        last_owner = 1;

        step();
        step();
        chk("rst_gnt", gnt, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_mcyc", m_cyc, 0);
        chk("rst_mstb", m_stb, 0);
        chk("rst_madr", m_adr, 0);
        chk("rst_s0ack", so_ack[0], 0);
        chk("rst_s1err", so_err[1], 0);
        chk("rst_s0dat", so_dat[0], 0);
        rst = 1'b0;
        step();

        // Four contention rounds: requester 0 first every time.
        for (int r = 0; r < 4; r++) begin
            setup(0, 32'h100 + r, $urandom(), 1'b0, r, 0, $urandom());
            setup(1, 32'h200 + r, $urandom(), 1'b1, 1, 0, $urandom());
            round(3);
        end

        // Single read from requester 0.
        setup(0, 32'h0000_1000, 32'h0, 1'b0, 0, 0, 32'hDEAD_BEEF);
        round(1);

        // Requester 1 stalls forever: watchdog abort.
        setup(1, 32'h0000_2000, 32'h1234_5678, 1'b1, 100, 0, 32'h0);
        round(2);

        // Ack on the last permitted stall cycle completes normally.
        setup(1, 32'h0000_3000, 32'h0, 1'b0, TMO - 1, 0, 32'hCAFE_F00D);
        round(2);

        // Bus error forwarded to the owner.
        setup(0, 32'h0000_4000, 32'h0, 1'b0, 3, 1, 32'h5555_AAAA);
        round(1);

        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 2; k++) begin
                setup(k, $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 10), ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom());
            end
            round($urandom_range(1, 3));
        end

        // Reset in the middle of a stalled requester-0 cycle.
        setup(0, 32'h0000_5000, 32'h0, 1'b0, 0, 0, 32'h0BAD_F00D);
        s_cyc[0] = 1'b1;
        s_stb[0] = 1'b1;
        step();
        chk("mid_gnt_before", gnt, 2'b01);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_cyc", m_cyc, 0);
        chk("mid_rst_stb", m_stb, 0);
        chk("mid_rst_gnt", gnt, 0);
        step();
        setup(1, 32'h0000_6000, 32'h0, 1'b0, 2, 0, 32'h7777_1111);
        s_cyc[1] = 1'b1;
        s_stb[1] = 1'b1;
        rst = 1'b0;
        last_owner = 1;
        step();
        serve(0);
        last_owner = 0;
        step();
        serve(1);
        last_owner = 1;

        // Disabled watchdog: a very long stall never aborts.
        z_cyc = 1'b1;
        z_stb = 1'b1;
        step();
        chk("z_gnt_start", z_gnt, 2'b01);
        zt = 0;
        for (int c = 0; c < 70000; c++) begin
            step();
            if (z_tmo !== 1'b0 || z_err0 !== 1'b0) zt++;
        end
        chk("z_no_timeout", zt, 0);
        chk("z_gnt_held", z_gnt, 2'b01);
        chk("z_cyc_held", z_mcyc, 1);
        z_cyc = 1'b0;
        z_stb = 1'b0;
        step();
        step();
        chk("z_idle", z_gnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
